// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch stage. Fetches a 32-bit instruction one byte
//            per memory response, assembles it little-endian and presents it
//            to decode. Supports stall, redirect (jump) and global freeze.
// Ports    : clk            - clock, all state on rising edge
//            rst            - synchronous active-low reset
//            rdy            - global ready; 0 freezes all state
//            mem_req        - byte fetch request (registered)
//            mem_addr       - byte address being requested (registered)
//            mem_byte       - returned byte
//            mem_byte_valid - mem_byte valid for mem_addr this cycle
//            id_stall       - decode cannot accept this cycle
//            jump_or_not    - redirect, flushes the current fetch
//            jump_addr      - redirect target
//            pc_o / inst_o  - presented PC / instruction (registered)
//            if_id_rdy      - pc_o/inst_o valid for decode (registered)
// Config   : ICACHE_EN - when defined, adds a 32-entry direct-mapped I-cache
//            (index pc[6:2], tag pc[31:7]) looked up in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_byte,
  input  logic        mem_byte_valid,
  input  logic        id_stall,
  input  logic        jump_or_not,
  input  logic [31:0] jump_addr,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        if_id_rdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [23:0] byte_buf, byte_buf_nxt;   // lower three bytes of the word in flight
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic [31:0] pc_o_nxt;
  logic [31:0] inst_o_nxt;
  logic        if_id_rdy_nxt;

`ifdef ICACHE_EN
  logic        cache_valid [32];
  logic [24:0] cache_tag   [32];
  logic [31:0] cache_data  [32];
  logic        cache_hit;
  logic        fill_we;

  assign cache_hit = cache_valid[pc[6:2]] && (cache_tag[pc[6:2]] == pc[31:7]);

  // pc is stable through a fill, so it supplies both index and tag on write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) cache_valid[i] <= 1'b0;
    end else if (rdy && fill_we) begin
      cache_valid[pc[6:2]] <= 1'b1;
      cache_tag[pc[6:2]]   <= pc[31:7];
      cache_data[pc[6:2]]  <= {mem_byte, byte_buf};
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    cnt_nxt       = cnt;
    byte_buf_nxt  = byte_buf;
    mem_req_nxt   = mem_req;
    mem_addr_nxt  = mem_addr;
    pc_o_nxt      = pc_o;
    inst_o_nxt    = inst_o;
    if_id_rdy_nxt = if_id_rdy;
`ifdef ICACHE_EN
    fill_we       = 1'b0;
`endif

    if (jump_or_not) begin
      // Redirect wins over everything: a byte arriving now is dropped and
      // no cache fill happens.
      state_nxt     = IDLE;
      pc_nxt        = jump_addr;
      cnt_nxt       = 2'd0;
      mem_req_nxt   = 1'b0;
      if_id_rdy_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef ICACHE_EN
          if (cache_hit) begin
            state_nxt     = HOLD;
            pc_o_nxt      = pc;
            inst_o_nxt    = cache_data[pc[6:2]];
            if_id_rdy_nxt = 1'b1;
          end else begin
            state_nxt    = FETCH;
            cnt_nxt      = 2'd0;
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc;
          end
`else
          state_nxt    = FETCH;
          cnt_nxt      = 2'd0;
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = pc;
`endif
        end

        FETCH: begin
          if (mem_byte_valid) begin
            case (cnt)
              2'd0: byte_buf_nxt[7:0]   = mem_byte;
              2'd1: byte_buf_nxt[15:8]  = mem_byte;
              2'd2: byte_buf_nxt[23:16] = mem_byte;
              default: ;
            endcase
            if (cnt == 2'd3) begin
              state_nxt     = HOLD;
              cnt_nxt       = 2'd0;
              mem_req_nxt   = 1'b0;
              pc_o_nxt      = pc;
              inst_o_nxt    = {mem_byte, byte_buf};
              if_id_rdy_nxt = 1'b1;
`ifdef ICACHE_EN
              fill_we       = 1'b1;
`endif
            end else begin
              cnt_nxt      = cnt + 2'd1;
              mem_addr_nxt = pc + {30'd0, cnt} + 32'd1;
            end
          end
        end

        HOLD: begin
          if (!id_stall) begin
            // Consume and go straight to fetching the next sequential word.
            state_nxt     = FETCH;
            pc_nxt        = pc + 32'd4;
            cnt_nxt       = 2'd0;
            mem_req_nxt   = 1'b1;
            mem_addr_nxt  = pc + 32'd4;
            if_id_rdy_nxt = 1'b0;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= 32'd0;
      cnt       <= 2'd0;
      byte_buf  <= 24'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      pc_o      <= 32'd0;
      inst_o    <= 32'd0;
      if_id_rdy <= 1'b0;
    end else if (rdy) begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      cnt       <= cnt_nxt;
      byte_buf  <= byte_buf_nxt;
      mem_req   <= mem_req_nxt;
      mem_addr  <= mem_addr_nxt;
      pc_o      <= pc_o_nxt;
      inst_o    <= inst_o_nxt;
      if_id_rdy <= if_id_rdy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed self-checking bench for if_fetch (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        mem_byte_valid;
  logic        id_stall;
  logic        jump_or_not;
  logic [31:0] jump_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        if_id_rdy;

  int checks = 0;
  int errors = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_byte       (mem_byte),
    .mem_byte_valid (mem_byte_valid),
    .id_stall       (id_stall),
    .jump_or_not    (jump_or_not),
    .jump_addr      (jump_addr),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .if_id_rdy      (if_id_rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for the currently requested address, checking the request.
  task automatic give_byte(input string tag, input logic [7:0] b, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    mem_byte_valid = 1'b1;
    mem_byte       = b;
    step();
    mem_byte_valid = 1'b0;
    mem_byte       = 8'h00;
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_rdy"},  {31'd0, if_id_rdy}, 32'd1);
    chk({tag, "_pc"},   pc_o, pc);
    chk({tag, "_inst"}, inst_o, inst);
    chk({tag, "_req0"}, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},  {31'd0, mem_req}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_pc"},   pc_o, 32'd0);
    chk({tag, "_inst"}, inst_o, 32'd0);
    chk({tag, "_rdy"},  {31'd0, if_id_rdy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; mem_byte = 8'h00; mem_byte_valid = 1'b0;
    id_stall = 1'b0; jump_or_not = 1'b0; jump_addr = 32'd0;
    step(); step();
    chk_reset("reset");

    // Basic fetch of 0x00000013 from address 0.
    rst = 1'b1;
    step();                                   // IDLE -> FETCH
    give_byte("b0", 8'h13, 32'd0);
    give_byte("b1", 8'h00, 32'd1);
    give_byte("b2", 8'h00, 32'd2);
    give_byte("b3", 8'h00, 32'd3);
    chk_hold("w0", 32'd0, 32'h0000_0013);

    // Stall three cycles, then consume.
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_hold("stall", 32'd0, 32'h0000_0013);
    end
    id_stall = 1'b0;
    step();
    chk("cons_rdy", {31'd0, if_id_rdy}, 32'd0);

    // Bytes with 2-cycle gaps; address must only move on valid bytes.
    give_byte("g0", 8'h93, 32'd4);
    step(); step();
    chk("gap_addr", mem_addr, 32'd5);
    give_byte("g1", 8'h00, 32'd5);
    step(); step();
    give_byte("g2", 8'h10, 32'd6);
    step(); step();
    give_byte("g3", 8'h00, 32'd7);
    chk_hold("w1", 32'd4, 32'h0010_0093);
    step();                                   // consume, fetch at 8

    // Jump after two bytes, with a byte arriving in the jump cycle.
    give_byte("j0", 8'hAA, 32'd8);
    give_byte("j1", 8'hBB, 32'd9);
    jump_or_not = 1'b1; jump_addr = 32'h100;
    mem_byte_valid = 1'b1; mem_byte = 8'hCC;
    step();
    jump_or_not = 1'b0; mem_byte_valid = 1'b0; mem_byte = 8'h00;
    chk("jmp_req", {31'd0, mem_req}, 32'd0);
    chk("jmp_rdy", {31'd0, if_id_rdy}, 32'd0);
    step();                                   // IDLE -> FETCH at 0x100
    give_byte("t0", 8'hB7, 32'h100);
    give_byte("t1", 8'h02, 32'h101);
    give_byte("t2", 8'h00, 32'h102);
    give_byte("t3", 8'h00, 32'h103);
    chk_hold("w2", 32'h100, 32'h0000_02B7);

    // rdy=0 freezes even a consuming edge.
    rdy = 1'b0;
    step(); step();
    chk_hold("frz", 32'h100, 32'h0000_02B7);
    rdy = 1'b1;
    step();
    chk("unfrz_addr", mem_addr, 32'h104);

    // Reset after three bytes, asserted together with a jump.
    give_byte("r0", 8'h11, 32'h104);
    give_byte("r1", 8'h22, 32'h105);
    give_byte("r2", 8'h33, 32'h106);
    rst = 1'b0; jump_or_not = 1'b1; jump_addr = 32'h200;
    mem_byte_valid = 1'b1; mem_byte = 8'h44;
    step();
    rst = 1'b1; jump_or_not = 1'b0; mem_byte_valid = 1'b0; mem_byte = 8'h00;
    chk_reset("midrst");
    step();
    give_byte("s0", 8'h6F, 32'd0);
    give_byte("s1", 8'h00, 32'd1);
    give_byte("s2", 8'h00, 32'd2);
    give_byte("s3", 8'h00, 32'd3);
    chk_hold("w3", 32'd0, 32'h0000_006F);

    // Jump overrides a simultaneous consume in HOLD.
    jump_or_not = 1'b1; jump_addr = 32'h40;
    step();
    jump_or_not = 1'b0;
    chk("jh_req", {31'd0, mem_req}, 32'd0);
    chk("jh_rdy", {31'd0, if_id_rdy}, 32'd0);
    step();
    chk("jh_addr", mem_addr, 32'h40);
    chk("jh_req1", {31'd0, mem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have ports: rdy  in  1  global ready; 0 freezes all state.
REQ-004 SHALL have ports: mem_req  out  1  instruction byte-fetch request.
REQ-005 SHALL have ports: mem_addr  out  32  byte address of the requested byte.
REQ-006 SHALL have ports: mem_byte  in  8  returned byte.
REQ-007 SHALL have ports: mem_byte_valid  in  1  mem_byte valid this cycle for mem_addr.
REQ-008 SHALL have ports: id_stall  in  1  decode cannot accept this cycle.
REQ-009 SHALL have ports: jump_or_not  in  1  redirect, flush current fetch.
REQ-010 SHALL have ports: jump_addr  in  32  redirect target.
REQ-011 SHALL have ports: pc_o  out  32  PC of the presented instruction.
REQ-012 SHALL have ports: inst_o  out  32  presented instruction.
REQ-013 SHALL have ports: if_id_rdy  out  1  pc_o/inst_o valid for decode.

Function
REQ-014 SHALL implement states IDLE, FETCH, HOLD; all outputs registered.
REQ-015 IDLE SHALL go to FETCH next cycle with byte counter = 0.
REQ-016 In FETCH, mem_req SHALL be 1 and mem_addr SHALL = pc + counter (wraps mod 2^32).
REQ-017 Each cycle with mem_byte_valid=1, mem_byte SHALL go to inst byte lane [counter], little-endian, and counter SHALL increment.
REQ-018 On the 4th byte, the block SHALL go to HOLD next cycle with if_id_rdy=1, pc_o=pc and inst_o = the assembled word.
REQ-019 mem_req SHALL be 0 in IDLE and HOLD.
REQ-020 In HOLD, an edge with id_stall=0 and jump_or_not=0 SHALL consume the instruction: pc<=pc+4, if_id_rdy<=0, state<=FETCH.
REQ-021 While id_stall=1 in HOLD, pc_o, inst_o and if_id_rdy SHALL hold.
REQ-022 jump_or_not=1 in any state SHALL set pc<=jump_addr, counter<=0, if_id_rdy<=0 and state<=IDLE.
REQ-023 A byte arriving in the jump cycle SHALL be discarded.
REQ-024 Jump SHALL override simultaneous consumption, byte arrival and cache hit.
REQ-025 With rdy=0, all registers SHALL hold and mem_req SHALL hold its value.

Reset
REQ-026 With rst=0 at an edge: pc=0, state=IDLE, counter=0, mem_req=0, mem_addr=0, pc_o=0, inst_o=0, if_id_rdy=0.
REQ-027 Reset SHALL take priority over rdy and jump_or_not.
REQ-028 Reset mid-FETCH SHALL abandon the partial word.

Configuration
REQ-029 Macro ICACHE_EN defined: 32-entry direct-mapped I-cache, index pc[6:2], tag pc[31:7], valid bits cleared on reset.
REQ-030 With ICACHE_EN, a hit in IDLE SHALL go directly to HOLD next cycle with mem_req never asserted.
REQ-031 With ICACHE_EN, a miss SHALL fetch as in REQ-016 to REQ-018 and write the entry on the 4th byte.
REQ-032 A jump during a miss fill SHALL leave the entry unwritten.
REQ-033 ICACHE_EN undefined: no cache storage; every instruction fetched from memory.

Verification
REQ-034 Reset, then mem returns 0x13,0x00,0x00,0x00 on consecutive cycles -> mem_addr 0,1,2,3; if_id_rdy=1 with pc_o=0, inst_o=0x00000013 the cycle after the 4th byte.
REQ-035 HOLD with id_stall=1 for 3 cycles -> outputs stable; id_stall=0 -> next fetch mem_addr=4.
REQ-036 jump_or_not=1, jump_addr=0x100 after 2 bytes fetched -> partial discarded; fetch restarts at 0x100; pc_o=0x100.
REQ-037 rst=0 mid-FETCH after 3 bytes -> all outputs per REQ-026; fetch restarts at address 0.
REQ-038 mem_byte_valid gaps of 2 cycles between bytes -> correct assembly; mem_addr advances only on valid.
REQ-039 ICACHE_EN: loop 0x0 to 0x8 jumping back to 0x0 -> second pass has zero mem_req cycles; HOLD one cycle after IDLE.
